// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480 raster timing constants and position helpers
package vga_timing_pkg;

    localparam int POS_W = 10;

    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int DEF_H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    function automatic logic in_window(input logic [POS_W-1:0] p,
                                       input logic [POS_W-1:0] lo,
                                       input logic [POS_W-1:0] hi);
        return (p >= lo) && (p <= hi);
    endfunction

endpackage

// File: rtl/vga_scan_timer_if.sv
// rtl/vga_scan_timer_if.sv - raster timing bundle from the scan timer to display consumers
interface vga_scan_timer_if
    import vga_timing_pkg::*;
#(
    parameter int FRAME_W = 8
);
    logic [POS_W-1:0]   hpos;
    logic [POS_W-1:0]   vpos;
    logic               hsync;
    logic               vsync;
    logic               display_on;
    logic               line_start;
    logic               frame_start;
    logic               vblank_start;
    logic [FRAME_W-1:0] frame_count;
    logic [POS_W-1:0]   fetch_x;
    logic [POS_W-1:0]   fetch_y;
    logic               fetch_active;

    modport master (
        output hpos, vpos, hsync, vsync, display_on, line_start, frame_start,
               vblank_start, frame_count, fetch_x, fetch_y, fetch_active
    );

    modport slave (
        input  hpos, vpos, hsync, vsync, display_on, line_start, frame_start,
               vblank_start, frame_count, fetch_x, fetch_y, fetch_active
    );
endinterface

// File: rtl/scan_counter_2d.sv
// rtl/scan_counter_2d.sv - x/y raster wrap counter with configurable reset position
module scan_counter_2d #(
    parameter int W       = 10,
    parameter int X_TOTAL = 800,
    parameter int Y_TOTAL = 525,
    parameter int RESET_X = 0,
    parameter int RESET_Y = 0
) (
    input  logic         clk,
    input  logic         reset,
    output logic [W-1:0] x,
    output logic [W-1:0] y,
    output logic [W-1:0] next_x,
    output logic [W-1:0] next_y
);
    logic last_x;
    logic last_y;

    // next_* is exposed so the owner can decode registered outputs aligned with x/y
    always_comb begin
        last_x = (x == W'(X_TOTAL - 1));
        last_y = (y == W'(Y_TOTAL - 1));
        next_x = last_x ? '0 : x + W'(1);
        next_y = y;
        if (last_x) begin
            next_y = last_y ? '0 : y + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x <= W'(RESET_X);
            y <= W'(RESET_Y);
        end else begin
            x <= next_x;
            y <= next_y;
        end
    end
endmodule

// File: rtl/vga_scan_timer.sv
// rtl/vga_scan_timer.sv - raster timing source: position, sync, blanking, events, fetch look-ahead
module vga_scan_timer
    import vga_timing_pkg::*;
#(
    parameter int   H_DISPLAY   = DEF_H_DISPLAY,
    parameter int   H_FRONT     = DEF_H_FRONT,
    parameter int   H_SYNC      = DEF_H_SYNC,
    parameter int   H_BACK      = DEF_H_BACK,
    parameter int   V_DISPLAY   = DEF_V_DISPLAY,
    parameter int   V_FRONT     = DEF_V_FRONT,
    parameter int   V_SYNC      = DEF_V_SYNC,
    parameter int   V_BACK      = DEF_V_BACK,
    parameter logic SYNC_ACTIVE = 1'b0,
    parameter int   LOOKAHEAD   = 2,
    parameter int   FRAME_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    vga_scan_timer_if.master  vif
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [POS_W-1:0] H_VIS   = POS_W'(H_DISPLAY);
    localparam logic [POS_W-1:0] V_VIS   = POS_W'(V_DISPLAY);
    localparam logic [POS_W-1:0] HS_LO   = POS_W'(H_DISPLAY + H_FRONT);
    localparam logic [POS_W-1:0] HS_HI   = POS_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [POS_W-1:0] VS_LO   = POS_W'(V_DISPLAY + V_FRONT);
    localparam logic [POS_W-1:0] VS_HI   = POS_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [POS_W-1:0] scan_x, scan_y, scan_nx, scan_ny;
    logic [POS_W-1:0] fetch_x, fetch_y, fetch_nx, fetch_ny;

    logic               hsync_q, vsync_q, display_on_q;
    logic               line_start_q, frame_start_q, vblank_start_q;
    logic [FRAME_W-1:0] frame_count_q;
    logic               fetch_active_q;

    scan_counter_2d #(
        .W(POS_W), .X_TOTAL(H_TOTAL), .Y_TOTAL(V_TOTAL),
        .RESET_X(H_TOTAL - 1), .RESET_Y(V_TOTAL - 1)
    ) u_scan (
        .clk(clk), .reset(reset),
        .x(scan_x), .y(scan_y), .next_x(scan_nx), .next_y(scan_ny)
    );

    // Starts LOOKAHEAD positions past the scan reset point, i.e. just across the frame wrap
    scan_counter_2d #(
        .W(POS_W), .X_TOTAL(H_TOTAL), .Y_TOTAL(V_TOTAL),
        .RESET_X(LOOKAHEAD - 1), .RESET_Y(0)
    ) u_fetch (
        .clk(clk), .reset(reset),
        .x(fetch_x), .y(fetch_y), .next_x(fetch_nx), .next_y(fetch_ny)
    );

    // Decoding the next position keeps every flag coincident with the registered hpos/vpos
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync_q        <= ~SYNC_ACTIVE;
            vsync_q        <= ~SYNC_ACTIVE;
            display_on_q   <= 1'b0;
            line_start_q   <= 1'b0;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
            frame_count_q  <= '1;
            fetch_active_q <= 1'b1;
        end else begin
            hsync_q        <= in_window(scan_nx, HS_LO, HS_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync_q        <= in_window(scan_ny, VS_LO, VS_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            display_on_q   <= (scan_nx < H_VIS) && (scan_ny < V_VIS);
            line_start_q   <= (scan_nx == '0);
            frame_start_q  <= (scan_nx == '0) && (scan_ny == '0);
            vblank_start_q <= (scan_nx == '0) && (scan_ny == V_VIS);
            if ((scan_nx == '0) && (scan_ny == '0)) begin
                frame_count_q <= frame_count_q + FRAME_W'(1);
            end
            fetch_active_q <= (fetch_nx < H_VIS) && (fetch_ny < V_VIS);
        end
    end

    assign vif.hpos         = scan_x;
    assign vif.vpos         = scan_y;
    assign vif.hsync        = hsync_q;
    assign vif.vsync        = vsync_q;
    assign vif.display_on   = display_on_q;
    assign vif.line_start   = line_start_q;
    assign vif.frame_start  = frame_start_q;
    assign vif.vblank_start = vblank_start_q;
    assign vif.frame_count  = frame_count_q;
    assign vif.fetch_x      = fetch_x;
    assign vif.fetch_y      = fetch_y;
    assign vif.fetch_active = fetch_active_q;
endmodule

// File: tb/tb_vga_scan_timer.sv
// tb/tb_vga_scan_timer.sv - scoreboard bench for vga_scan_timer at 640x480 and a reduced raster
module tb_vga_scan_timer;

    typedef struct packed {
        int   hd, hf, hs, hb, vd, vf, vs, vb, la, fw;
        logic sa;
    } cfg_t;

    typedef struct packed {
        logic [9:0] hpos;
        logic [9:0] vpos;
        logic       hsync;
        logic       vsync;
        logic       display_on;
        logic       line_start;
        logic       frame_start;
        logic       vblank_start;
        logic [7:0] frame_count;
        logic [9:0] fetch_x;
        logic [9:0] fetch_y;
        logic       fetch_active;
    } obs_t;

    localparam cfg_t CFG_A = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 8, 1'b0};
    localparam cfg_t CFG_B = '{8, 2, 3, 3, 6, 1, 2, 2, 3, 2, 1'b1};

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   checks = 0;
    int   errors = 0;
    bit   done_a = 0, done_b = 0;

    obs_t    q_a[$];
    obs_t    q_b[$];
    longint  k_a, k_b;
    bit      inr_a, inr_b;

    always #5 clk = ~clk;

    vga_scan_timer_if #(.FRAME_W(8)) if_a ();
    vga_scan_timer_if #(.FRAME_W(2)) if_b ();

    vga_scan_timer dut_a (.clk(clk), .reset(rst_a), .vif(if_a));

    vga_scan_timer #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .SYNC_ACTIVE(1'b1), .LOOKAHEAD(3), .FRAME_W(2)
    ) dut_b (.clk(clk), .reset(rst_b), .vif(if_b));

    // Expected outputs after k edges since reset release, from the linear scan index k-1
    function automatic obs_t model(input cfg_t c, input longint k);
        obs_t   o;
        longint ht, vt, f, l, lf, fr, h, v, fx, fy;
        ht = c.hd + c.hf + c.hs + c.hb;
        vt = c.vd + c.vf + c.vs + c.vb;
        f  = ht * vt;
        l  = k - 1;
        if (l < 0) begin
            l  = l + f;
            fr = -1;
        end else begin
            fr = l / f;
        end
        l  = l % f;
        h  = l % ht;
        v  = l / ht;
        lf = (k - 1 + c.la) % f;
        fx = lf % ht;
        fy = lf / ht;
        o.hpos         = 10'(h);
        o.vpos         = 10'(v);
        o.hsync        = (h >= c.hd + c.hf && h < c.hd + c.hf + c.hs) ? c.sa : ~c.sa;
        o.vsync        = (v >= c.vd + c.vf && v < c.vd + c.vf + c.vs) ? c.sa : ~c.sa;
        o.display_on   = (h < c.hd) && (v < c.vd);
        o.line_start   = (k > 0) && (h == 0);
        o.frame_start  = (k > 0) && (h == 0) && (v == 0);
        o.vblank_start = (k > 0) && (h == 0) && (v == c.vd);
        o.frame_count  = 8'(fr) & 8'((1 << c.fw) - 1);
        o.fetch_x      = 10'(fx);
        o.fetch_y      = 10'(fy);
        o.fetch_active = (fx < c.hd) && (fy < c.vd);
        return o;
    endfunction

    task automatic cycle_a(input logic r);
        @(posedge clk);
        if (!inr_a) k_a++;
        #2;
        rst_a = r;
        inr_a = r;
        if (r) k_a = 0;
        q_a.push_back(model(CFG_A, k_a));
    endtask

    task automatic cycle_b(input logic r);
        @(posedge clk);
        if (!inr_b) k_b++;
        #2;
        rst_b = r;
        inr_b = r;
        if (r) k_b = 0;
        q_b.push_back(model(CFG_B, k_b));
    endtask

    initial begin
        rst_a = 1'b1; inr_a = 1; k_a = 0;
        repeat (3) cycle_a(1'b1);
        cycle_a(1'b0);
        repeat (2500) cycle_a(1'b0);
        // Land on hpos 300, then assert reset between that edge and the next
        while (model(CFG_A, k_a + 1).hpos != 10'd300) cycle_a(1'b0);
        cycle_a(1'b1);
        repeat (2) cycle_a(1'b1);
        cycle_a(1'b0);
        repeat (1000) cycle_a(1'b0);
        repeat ($urandom_range(50, 900)) cycle_a(1'b0);
        cycle_a(1'b1);
        cycle_a(1'b0);
        repeat (300) cycle_a(1'b0);
        done_a = 1;
    end

    initial begin
        rst_b = 1'b1; inr_b = 1; k_b = 0;
        repeat (2) cycle_b(1'b1);
        cycle_b(1'b0);
        repeat (5 * 16 * 11 + 20) cycle_b(1'b0);
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(1, 400)) cycle_b(1'b0);
            repeat ($urandom_range(1, 3)) cycle_b(1'b1);
            cycle_b(1'b0);
        end
        repeat (200) cycle_b(1'b0);
        done_b = 1;
    end

    always @(negedge clk) begin
        obs_t e, a;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            a = '{if_a.hpos, if_a.vpos, if_a.hsync, if_a.vsync, if_a.display_on,
                  if_a.line_start, if_a.frame_start, if_a.vblank_start, if_a.frame_count,
                  if_a.fetch_x, if_a.fetch_y, if_a.fetch_active};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL scan_a t=%0t got=%h want=%h (hpos %0d/%0d vpos %0d/%0d)",
                         $time, a, e, a.hpos, e.hpos, a.vpos, e.vpos);
            end
        end
    end

    always @(negedge clk) begin
        obs_t e, a;
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            a = '{if_b.hpos, if_b.vpos, if_b.hsync, if_b.vsync, if_b.display_on,
                  if_b.line_start, if_b.frame_start, if_b.vblank_start, 8'(if_b.frame_count),
                  if_b.fetch_x, if_b.fetch_y, if_b.fetch_active};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL scan_b t=%0t got=%h want=%h (hpos %0d/%0d vpos %0d/%0d fc %0d/%0d)",
                         $time, a, e, a.hpos, e.hpos, a.vpos, e.vpos, a.frame_count, e.frame_count);
            end
        end
    end

    initial begin
        fork
            wait (done_a && done_b);
            #1_000_000;
        join_any
        disable fork;
        checks++;
        if (!(done_a && done_b)) begin
            errors++;
            $display("FAIL timeout done_a=%0d done_b=%0d want 1/1", done_a, done_b);
        end
        repeat (2) @(posedge clk);
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL drain q_a=%0d q_b=%0d want 0/0", q_a.size(), q_b.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
